// File: rtl/reaction_timer_fsm_if.sv
// Player-facing signal bundle of the reaction timer: raw keys and 1 ms divider in,
// GO LED and millisecond result out.
interface reaction_timer_fsm_if;
  logic        clk_1ms;
  logic        start_n;
  logic        react_n;
  logic        go_led;
  logic [13:0] reaction_ms;
  logic        result_valid;
  logic        false_start;
  logic        busy;

  modport master (
    output clk_1ms, start_n, react_n,
    input  go_led, reaction_ms, result_valid, false_start, busy
  );

  modport slave (
    input  clk_1ms, start_n, react_n,
    output go_led, reaction_ms, result_valid, false_start, busy
  );
endinterface

// File: rtl/reaction_timer_fsm.sv
// Reaction-test controller: random pre-GO delay, GO LED, millisecond reaction count,
// false-start and timeout detection, all paced by the synchronised 1 ms divider toggle.
module reaction_timer_fsm #(
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int MAX_COUNT    = 9999
) (
  input  logic                clk,
  input  logic                reset,
  reaction_timer_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_GO    = 3'd2,
    ST_DONE  = 3'd3,
    ST_FALSE = 3'd4
  } state_t;

  localparam logic [13:0] MAX_CNT    = 14'(MAX_COUNT);
  localparam logic [13:0] MAX_CNT_M1 = 14'(MAX_COUNT - 1);
  localparam logic [15:0] MIN_DELAY  = 16'(MIN_DELAY_MS);
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  // Feedback parity for taps 16,14,13,11.
  function automatic logic lfsr_fb(input logic [15:0] v);
    return v[15] ^ v[13] ^ v[12] ^ v[10];
  endfunction

  logic [1:0]  ms_sync_r;
  logic        ms_hist_r;
  logic        tick_r;
  logic [1:0]  start_sync_r;
  logic        start_hist_r;
  logic        start_ev_r;
  logic [1:0]  react_sync_r;
  logic        react_hist_r;
  logic        react_ev_r;

  logic [15:0] lfsr_r;
  state_t      state_r;
  logic [15:0] delay_r;
  logic [13:0] count_r;
  logic        go_led_r;
  logic        result_valid_r;
  logic        false_start_r;
  logic        busy_r;

  state_t      state_nxt_s;
  logic [15:0] delay_nxt_s;
  logic [13:0] count_nxt_s;
  logic [15:0] delay_load_s;

  assign delay_load_s = MIN_DELAY + 16'(lfsr_r[RAND_BITS-1:0]);

  // Input synchronisers with registered edge detectors (keys reset to released).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_sync_r    <= 2'b00;
      ms_hist_r    <= 1'b0;
      tick_r       <= 1'b0;
      start_sync_r <= 2'b11;
      start_hist_r <= 1'b1;
      start_ev_r   <= 1'b0;
      react_sync_r <= 2'b11;
      react_hist_r <= 1'b1;
      react_ev_r   <= 1'b0;
    end else begin
      ms_sync_r    <= {ms_sync_r[0], bus.clk_1ms};
      ms_hist_r    <= ms_sync_r[1];
      tick_r       <= ms_sync_r[1] ^ ms_hist_r;
      start_sync_r <= {start_sync_r[0], bus.start_n};
      start_hist_r <= start_sync_r[1];
      start_ev_r   <= start_hist_r & ~start_sync_r[1];
      react_sync_r <= {react_sync_r[0], bus.react_n};
      react_hist_r <= react_sync_r[1];
      react_ev_r   <= react_hist_r & ~react_sync_r[1];
    end
  end

  // Free-running LFSR; a nonzero seed keeps it out of the all-zero lock-up state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_fb(lfsr_r)};
    end
  end

  // Next-state logic; react_ev takes priority over a coincident tick.
  always_comb begin
    state_nxt_s = state_r;
    delay_nxt_s = delay_r;
    count_nxt_s = count_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_FALSE: begin
        if (start_ev_r) begin
          state_nxt_s = ST_ARMED;
          delay_nxt_s = delay_load_s;
          count_nxt_s = 14'd0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_ARMED: begin
        if (react_ev_r) begin
          state_nxt_s = ST_FALSE;
        end else if (tick_r) begin
          if (delay_r <= 16'd1) begin
            state_nxt_s = ST_GO;
            delay_nxt_s = 16'd0;
            count_nxt_s = 14'd0;
          end else begin
            delay_nxt_s = delay_r - 16'd1;
          end
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_GO: begin
        if (react_ev_r) begin
          state_nxt_s = ST_DONE;
        end else if (tick_r) begin
          if (count_r >= MAX_CNT_M1) begin
            state_nxt_s = ST_DONE;
            count_nxt_s = MAX_CNT;
          end else begin
            count_nxt_s = count_r + 14'd1;
          end
        end else begin
          state_nxt_s = ST_GO;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        delay_nxt_s = 16'd0;
        count_nxt_s = 14'd0;
      end
    endcase
  end

  // State, counters and state-decoded outputs registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      delay_r        <= 16'd0;
      count_r        <= 14'd0;
      go_led_r       <= 1'b0;
      result_valid_r <= 1'b0;
      false_start_r  <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      delay_r        <= delay_nxt_s;
      count_r        <= count_nxt_s;
      go_led_r       <= (state_nxt_s == ST_GO);
      result_valid_r <= (state_nxt_s == ST_DONE);
      false_start_r  <= (state_nxt_s == ST_FALSE);
      busy_r         <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_GO);
    end
  end

  assign bus.go_led       = go_led_r;
  assign bus.reaction_ms  = count_r;
  assign bus.result_valid = result_valid_r;
  assign bus.false_start  = false_start_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Directed bench for reaction_timer_fsm: two instances (long ceiling and 20 ms ceiling)
// share the same key and 1 ms stimulus.
module tb_reaction_timer_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_1ms = 1'b0;
  logic        start_n = 1'b1;
  logic        react_n = 1'b1;
  logic [15:0] m_lfsr;
  int          errors = 0;
  int          checks = 0;

  reaction_timer_fsm_if ifa ();
  reaction_timer_fsm_if ifb ();

  assign ifa.clk_1ms = clk_1ms;
  assign ifa.start_n = start_n;
  assign ifa.react_n = react_n;
  assign ifb.clk_1ms = clk_1ms;
  assign ifb.start_n = start_n;
  assign ifb.react_n = react_n;

  reaction_timer_fsm #(.MIN_DELAY_MS(4), .RAND_BITS(1), .MAX_COUNT(9999)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );
  reaction_timer_fsm #(.MIN_DELAY_MS(4), .RAND_BITS(1), .MAX_COUNT(20)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  always #10 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic ms_tick();
    @(negedge clk);
    clk_1ms = ~clk_1ms;
    repeat (20) @(negedge clk);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) ms_tick();
  endtask

  task automatic press_react();
    @(negedge clk);
    react_n = 1'b0;
    repeat (8) @(negedge clk);
    react_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic tick_with_react();
    @(negedge clk);
    clk_1ms = ~clk_1ms;
    react_n = 1'b0;
    repeat (20) @(negedge clk);
    react_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Press start and return the loaded delay, from the model LFSR value seen on the load edge.
  task automatic do_start(input bit hold, output int n);
    logic [15:0] saved;
    bit          seen;
    seen = 1'b0;
    @(negedge clk);
    saved = m_lfsr;
    start_n = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ifa.busy === 1'b1) begin
        seen = 1'b1;
        break;
      end
      saved = m_lfsr;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL start_busy: busy=%b after 12 clk, required 1", ifa.busy);
    end
    n = 4 + int'(saved[0]);
    if (!hold) start_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.go_led, ifa.result_valid, ifa.false_start, ifa.busy} !== 4'b0000 || ifa.reaction_ms !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: go/valid/false/busy=%b%b%b%b ms=%0d, required 0000 ms=0",
               ifa.go_led, ifa.result_valid, ifa.false_start, ifa.busy, ifa.reaction_ms);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy a=%b b=%b, required 0", ifa.busy, ifb.busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_start(1'b0, n);
    ticks(n);
    checks++;
    if (ifb.go_led !== 1'b1) begin
      errors++;
      $display("FAIL timeout_go: go_led=%b, required 1", ifb.go_led);
    end
    ticks(19);
    checks++;
    if (ifb.busy !== 1'b1 || ifb.result_valid !== 1'b0 || ifb.reaction_ms !== 14'd19) begin
      errors++;
      $display("FAIL timeout_19: busy=%b valid=%b ms=%0d, required 1 0 19", ifb.busy, ifb.result_valid, ifb.reaction_ms);
    end
    ms_tick();
    checks++;
    if (ifb.result_valid !== 1'b1 || ifb.reaction_ms !== 14'd20 || ifb.go_led !== 1'b0 || ifb.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_20: valid=%b ms=%0d go=%b busy=%b, required 1 20 0 0",
               ifb.result_valid, ifb.reaction_ms, ifb.go_led, ifb.busy);
    end
    press_react();
    checks++;
    if (ifb.result_valid !== 1'b1 || ifb.reaction_ms !== 14'd20 || ifb.false_start !== 1'b0) begin
      errors++;
      $display("FAIL timeout_react_ignored: valid=%b ms=%0d false=%b, required 1 20 0",
               ifb.result_valid, ifb.reaction_ms, ifb.false_start);
    end
    checks++;
    if (ifa.result_valid !== 1'b1 || ifa.reaction_ms !== 14'd20) begin
      errors++;
      $display("FAIL long_ceiling_react: valid=%b ms=%0d, required 1 20", ifa.result_valid, ifa.reaction_ms);
    end
  endtask

  task automatic test_normal();
    int n;
    do_start(1'b0, n);
    checks++;
    if (ifa.reaction_ms !== 14'd0 || ifa.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: ms=%0d valid=%b, required 0 0", ifa.reaction_ms, ifa.result_valid);
    end
    ticks(n - 1);
    checks++;
    if (ifa.go_led !== 1'b0 || ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL go_early: go=%b busy=%b after %0d ticks, required 0 1", ifa.go_led, ifa.busy, n - 1);
    end
    ms_tick();
    checks++;
    if (ifa.go_led !== 1'b1 || ifa.reaction_ms !== 14'd0) begin
      errors++;
      $display("FAIL go_on_time: go=%b ms=%0d after %0d ticks, required 1 0", ifa.go_led, ifa.reaction_ms, n);
    end
    ticks(37);
    press_react();
    checks++;
    if (ifa.result_valid !== 1'b1 || ifa.reaction_ms !== 14'd37 || ifa.go_led !== 1'b0 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL normal_37: valid=%b ms=%0d go=%b busy=%b, required 1 37 0 0",
               ifa.result_valid, ifa.reaction_ms, ifa.go_led, ifa.busy);
    end
  endtask

  task automatic test_false_start();
    int n;
    do_start(1'b0, n);
    ticks(2);
    press_react();
    checks++;
    if (ifa.false_start !== 1'b1 || ifa.busy !== 1'b0 || ifa.go_led !== 1'b0 || ifa.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL false_start: false=%b busy=%b go=%b valid=%b, required 1 0 0 0",
               ifa.false_start, ifa.busy, ifa.go_led, ifa.result_valid);
    end
    ticks(6);
    checks++;
    if (ifa.go_led !== 1'b0 || ifa.false_start !== 1'b1) begin
      errors++;
      $display("FAIL false_hold: go=%b false=%b, required 0 1", ifa.go_led, ifa.false_start);
    end
  endtask

  task automatic test_simul_armed();
    int n;
    do_start(1'b0, n);
    ticks(n - 1);
    tick_with_react();
    checks++;
    if (ifa.false_start !== 1'b1 || ifa.go_led !== 1'b0 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_armed: false=%b go=%b busy=%b, required 1 0 0", ifa.false_start, ifa.go_led, ifa.busy);
    end
  endtask

  task automatic test_simul_go();
    int n;
    do_start(1'b0, n);
    ticks(n + 12);
    checks++;
    if (ifa.go_led !== 1'b1 || ifa.reaction_ms !== 14'd12) begin
      errors++;
      $display("FAIL go_count_12: go=%b ms=%0d, required 1 12", ifa.go_led, ifa.reaction_ms);
    end
    tick_with_react();
    checks++;
    if (ifa.result_valid !== 1'b1 || ifa.reaction_ms !== 14'd12 || ifa.go_led !== 1'b0) begin
      errors++;
      $display("FAIL simul_go: valid=%b ms=%0d go=%b, required 1 12 0", ifa.result_valid, ifa.reaction_ms, ifa.go_led);
    end
  endtask

  task automatic test_ignored_start();
    int n;
    do_start(1'b0, n);
    ticks(n + 5);
    @(negedge clk);
    start_n = 1'b0;
    repeat (8) @(negedge clk);
    start_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (ifa.go_led !== 1'b1 || ifa.busy !== 1'b1 || ifa.reaction_ms !== 14'd5) begin
      errors++;
      $display("FAIL start_in_go: go=%b busy=%b ms=%0d, required 1 1 5", ifa.go_led, ifa.busy, ifa.reaction_ms);
    end
    ticks(2);
    press_react();
    checks++;
    if (ifa.result_valid !== 1'b1 || ifa.reaction_ms !== 14'd7) begin
      errors++;
      $display("FAIL after_ignored_start: valid=%b ms=%0d, required 1 7", ifa.result_valid, ifa.reaction_ms);
    end
  endtask

  task automatic test_held_start();
    int n;
    do_start(1'b1, n);
    ticks(n + 3);
    press_react();
    checks++;
    if (ifa.result_valid !== 1'b1 || ifa.reaction_ms !== 14'd3) begin
      errors++;
      $display("FAIL held_trial: valid=%b ms=%0d, required 1 3", ifa.result_valid, ifa.reaction_ms);
    end
    ticks(4);
    checks++;
    if (ifa.busy !== 1'b0 || ifa.result_valid !== 1'b1 || ifa.reaction_ms !== 14'd3) begin
      errors++;
      $display("FAIL held_no_retrigger: busy=%b valid=%b ms=%0d, required 0 1 3", ifa.busy, ifa.result_valid, ifa.reaction_ms);
    end
    start_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (ifa.busy !== 1'b0 || ifa.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL release_no_event: busy=%b valid=%b, required 0 1", ifa.busy, ifa.result_valid);
    end
  endtask

  task automatic test_reset_mid_go();
    int n;
    do_start(1'b0, n);
    ticks(n + 3);
    checks++;
    if (ifa.go_led !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_go: go=%b, required 1", ifa.go_led);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #2;
    checks++;
    if (ifa.go_led !== 1'b0 || ifa.busy !== 1'b0 || ifa.reaction_ms !== 14'd0 ||
        ifa.result_valid !== 1'b0 || ifa.false_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: go=%b busy=%b ms=%0d valid=%b false=%b, required 0 0 0 0 0",
               ifa.go_led, ifa.busy, ifa.reaction_ms, ifa.result_valid, ifa.false_start);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_normal();
    test_false_start();
    test_simul_armed();
    test_simul_go();
    test_ignored_start();
    test_held_start();
    test_reset_mid_go();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reaction_timer_fsm.md
# reaction_timer_fsm

Reaction-test controller that consumes the 1 ms toggling clock produced by the clock divider and runs one trial per start press. Each trial waits a pseudo-random delay, lights the GO LED, then measures the time in milliseconds until the player presses the react key. It flags presses made before GO as false starts. The block drives the GO LED and feeds the millisecond result to the display/BCD stage downstream.

## Interface
- MIN_DELAY_MS, 1000: fixed part of the pre-GO delay, in ms.
- RAND_BITS, 11: number of LFSR bits added to the delay (range 1..15), giving a random part of 0..2^RAND_BITS-1 ms.
- MAX_COUNT, 9999: reaction count ceiling, in ms; the timeout value.
- clk  in  1  50 MHz system clock; the only clock.
- reset  in  1  asynchronous, active-high; clears all state.
- clk_1ms  in  1  divider output; toggles every 1 ms; treated as data, never as a clock.
- start_n  in  1  raw KEY, active-low; asynchronous to clk.
- react_n  in  1  raw KEY, active-low; asynchronous to clk.
- go_led  out  1  high while the GO state is active.
- reaction_ms  out  14  measured time in binary, 0..MAX_COUNT.
- result_valid  out  1  high in DONE.
- false_start  out  1  high in FALSE.
- busy  out  1  high in ARMED or GO.

## Operation
- Synchronisers:
  - clk_1ms, start_n and react_n each pass through a 2-FF synchroniser, plus one history register.
  - tick: one-cycle pulse on every transition, rising or falling, of synced clk_1ms. Each tick marks 1 ms.
  - start_ev and react_ev: one-cycle pulses on the falling edge (press) of the synced keys. A held key produces exactly one event. No debounce is done here.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, reset seed 16'hACE1.
  - Advances every clk and never holds zero.
- Reset values:
  - State IDLE.
  - go_led, result_valid, false_start and busy all 0.
  - reaction_ms 0, delay counter 0.
- States and transitions:
  - IDLE: on start_ev, load delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0], clear reaction_ms, then go to ARMED.
  - ARMED: each tick decrements delay.
    - react_ev goes to FALSE.
    - A tick with delay==1 goes to GO and clears reaction_ms.
    - If react_ev and that final tick arrive in the same cycle, react_ev wins and the next state is FALSE.
  - GO: each tick increments reaction_ms.
    - react_ev goes to DONE and freezes reaction_ms at its pre-increment value. This also applies when a tick arrives in the same cycle.
    - A tick that makes reaction_ms reach MAX_COUNT goes to DONE with reaction_ms = MAX_COUNT (timeout).
  - DONE / FALSE: hold all results. start_ev starts a new trial exactly as from IDLE.
- start_ev is ignored in ARMED and GO.
- react_ev is ignored in IDLE, DONE and FALSE.
- Outputs are registered and decoded from state: go_led=GO, result_valid=DONE, false_start=FALSE, busy=ARMED|GO.
- reaction_ms keeps its last value until the next start_ev clears it.
- Delay width is 16 bits; MIN_DELAY_MS + 2^RAND_BITS-1 must be at most 65535.

## Timing
- Tick latency: clk_1ms edge to tick pulse is 3 clk, made up of 2 sync stages and 1 compare.
- Key latency: key falling edge to event pulse is 3 clk.
- State changes occur on the clk edge after the triggering event pulse. Outputs reflect the new state in that same cycle, since they are registered alongside state.
- GO is entered on the tick of the Nth ms, where N is the loaded delay.
- reaction_ms equals the number of ticks seen in GO before react_ev. Resolution is ±1 ms plus 6 clk of synchroniser skew.
- Asserting reset mid-trial forces IDLE and the reset values immediately, independent of clk.

## Test plan
- Reset mid-GO: assert reset while go_led=1 -> go_led, busy and reaction_ms read 0 with no clk edge.
- Normal trial, MIN_DELAY_MS=4, RAND_BITS=1, bench toggles clk_1ms every 20 clk:
  - Press start, then count ticks -> go_led rises after 4 or 5 ticks, matching lfsr[0] at the start_ev cycle.
  - Press react after 37 ticks in GO -> result_valid=1, reaction_ms=37, go_led=0.
- False start: press react during ARMED -> false_start=1, go_led never rises, busy=0.
- Simultaneous events:
  - react_ev coinciding with the final ARMED tick -> FALSE.
  - react_ev coinciding with a GO tick at count 12 -> DONE with reaction_ms=12.
- Timeout: MAX_COUNT=20, no react press -> DONE with reaction_ms=20 on the 20th GO tick; a later react press is ignored.
- Ignored and held keys:
  - start held low through a whole trial -> exactly one trial starts.
  - start_ev during GO -> no effect.
  - start_ev in DONE -> new trial with reaction_ms cleared to 0.
